// File: rtl/synth_cmd_decoder.sv
// ---------------------------------------------------------------------------
// synth_cmd_decoder
//
// Turns the UART receiver's byte stream into writes to the FM synth control
// registers and the per-voice carrier state. A command is an opcode byte
// followed by little-endian argument bytes. Note-start commands are placed
// in the lowest-index free voice.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   rx_data       byte from the UART receiver
//   rx_valid      rx_data holds a byte
//   rx_ready      decoder accepts a byte (handshake = rx_valid & rx_ready)
//   mod_fcw       modulator frequency control word
//   mod_shift     modulator shift
//   synth_shift   synth output shift
//   carrier_fcws  voice i carrier FCW at [i*FCW_WIDTH +: FCW_WIDTH]
//   note_en       voice i active
//   drop_pulse    one-cycle pulse when a command is discarded
// ---------------------------------------------------------------------------
module synth_cmd_decoder #(
   parameter int N_VOICES    = 4,
   parameter int FCW_WIDTH   = 24,
   parameter int SHIFT_WIDTH = 5
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [7:0]                    rx_data,
   input  logic                          rx_valid,
   output logic                          rx_ready,
   output logic [FCW_WIDTH-1:0]          mod_fcw,
   output logic [SHIFT_WIDTH-1:0]        mod_shift,
   output logic [SHIFT_WIDTH-1:0]        synth_shift,
   output logic [N_VOICES*FCW_WIDTH-1:0] carrier_fcws,
   output logic [N_VOICES-1:0]           note_en,
   output logic                          drop_pulse
);

   localparam int NB = FCW_WIDTH / 8;
   localparam int CW = $clog2(NB + 1);

   typedef enum logic [1:0] {
      IDLE,
      ARGS,
      EXEC
   } state_t;

   state_t                        r_state;
   state_t                        w_nextState;
   logic                          r_live;
   logic [2:0]                    r_opcode;
   logic [CW-1:0]                 r_argCnt;
   logic [CW-1:0]                 r_byteIdx;
   logic [FCW_WIDTH-1:0]          r_arg;
   logic [FCW_WIDTH-1:0]          r_modFcw;
   logic [SHIFT_WIDTH-1:0]        r_modShift;
   logic [SHIFT_WIDTH-1:0]        r_synthShift;
   logic [N_VOICES*FCW_WIDTH-1:0] r_carrierFcws;
   logic [N_VOICES-1:0]           r_noteEn;
   logic                          r_drop;

   logic                          w_handshake;
   logic                          w_opValid;
   logic [CW-1:0]                 w_opArgs;
   logic [N_VOICES-1:0]           w_match;
   logic [N_VOICES-1:0]           w_freeSel;
   logic                          w_freeFound;

   // Number of argument bytes that follow each opcode; unknown opcodes
   // report zero but are never latched.
   function automatic logic [CW-1:0] argCount(input logic [7:0] op);
      case (op)
         8'd1, 8'd3, 8'd4: argCount = CW'(NB);
         8'd2, 8'd5:       argCount = CW'(1);
         default:          argCount = '0;
      endcase
   endfunction

   // r_live holds rx_ready low while reset is asserted and for the first
   // edge after release, so no byte can be taken during reset.
   assign rx_ready    = r_live && (r_state != EXEC);
   assign w_handshake = rx_valid && rx_ready;
   assign w_opValid   = (rx_data >= 8'd1) && (rx_data <= 8'd6);
   assign w_opArgs    = argCount(rx_data);

   assign mod_fcw      = r_modFcw;
   assign mod_shift    = r_modShift;
   assign synth_shift  = r_synthShift;
   assign carrier_fcws = r_carrierFcws;
   assign note_en      = r_noteEn;
   assign drop_pulse   = r_drop;

   // State register for the command FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: IDLE waits for an opcode, ARGS collects argument
   // bytes, EXEC is a single cycle in which the command is applied.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_handshake && w_opValid) begin
               w_nextState = (w_opArgs != '0) ? ARGS : EXEC;
            end
         end
         ARGS: begin
            if (w_handshake && (r_argCnt == CW'(1))) begin
               w_nextState = EXEC;
            end
         end
         EXEC:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Voice matching and lowest-free-voice search over the argument FCW.
   always_comb begin
      w_match     = '0;
      w_freeSel   = '0;
      w_freeFound = 1'b0;
      for (int i = 0; i < N_VOICES; i++) begin
         w_match[i] = r_noteEn[i] &&
                      (r_carrierFcws[i*FCW_WIDTH +: FCW_WIDTH] == r_arg);
         if (!w_freeFound && !r_noteEn[i]) begin
            w_freeSel[i] = 1'b1;
            w_freeFound  = 1'b1;
         end
      end
   end

   // Datapath: opcode/argument capture and command execution. drop_pulse
   // defaults low every cycle so it is only ever a single-cycle pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_live        <= 1'b0;
         r_opcode      <= '0;
         r_argCnt      <= '0;
         r_byteIdx     <= '0;
         r_arg         <= '0;
         r_modFcw      <= '0;
         r_modShift    <= '0;
         r_synthShift  <= '0;
         r_carrierFcws <= '0;
         r_noteEn      <= '0;
         r_drop        <= 1'b0;
      end else begin
         r_live <= 1'b1;
         r_drop <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_handshake) begin
                  if (w_opValid) begin
                     r_opcode  <= rx_data[2:0];
                     r_argCnt  <= w_opArgs;
                     r_byteIdx <= '0;
                     r_arg     <= '0;
                  end else begin
                     r_drop <= 1'b1;
                  end
               end
            end
            ARGS: begin
               if (w_handshake) begin
                  for (int b = 0; b < NB; b++) begin
                     if (r_byteIdx == CW'(b)) begin
                        r_arg[b*8 +: 8] <= rx_data;
                     end
                  end
                  r_byteIdx <= r_byteIdx + CW'(1);
                  r_argCnt  <= r_argCnt - CW'(1);
               end
            end
            EXEC: begin
               case (r_opcode)
                  3'd1: r_modFcw     <= r_arg;
                  3'd2: r_modShift   <= r_arg[SHIFT_WIDTH-1:0];
                  3'd5: r_synthShift <= r_arg[SHIFT_WIDTH-1:0];
                  3'd6: r_noteEn     <= '0;
                  3'd3: begin
                     // A note already sounding is not duplicated.
                     if (|w_match || !w_freeFound) begin
                        r_drop <= 1'b1;
                     end else begin
                        for (int i = 0; i < N_VOICES; i++) begin
                           if (w_freeSel[i]) begin
                              r_carrierFcws[i*FCW_WIDTH +: FCW_WIDTH] <= r_arg;
                           end
                        end
                        r_noteEn <= r_noteEn | w_freeSel;
                     end
                  end
                  3'd4: begin
                     // Released voices keep their FCW; only the enable drops.
                     if (|w_match) begin
                        r_noteEn <= r_noteEn & ~w_match;
                     end else begin
                        r_drop <= 1'b1;
                     end
                  end
                  default: r_drop <= 1'b0;
               endcase
            end
            default: r_drop <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_synth_cmd_decoder.sv
// ---------------------------------------------------------------------------
// tb_synth_cmd_decoder
//
// Directed scoreboard bench for synth_cmd_decoder. The stimulus process
// pushes the hand-computed output snapshot expected after each command; the
// monitor pops and compares whenever the decoder responds (the cycle after
// EXEC, or a drop pulse).
// ---------------------------------------------------------------------------
module tb_synth_cmd_decoder;

   typedef struct packed {
      logic [23:0] modFcw;
      logic [4:0]  modShift;
      logic [4:0]  synthShift;
      logic [95:0] carriers;
      logic [3:0]  noteEn;
      logic        drop;
   } snap_t;

   logic        clk;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [23:0] mod_fcw;
   logic [4:0]  mod_shift;
   logic [4:0]  synth_shift;
   logic [95:0] carrier_fcws;
   logic [3:0]  note_en;
   logic        drop_pulse;

   snap_t expQ[$];
   snap_t expS;
   int    vectors     = 0;
   int    miscompares = 0;

   synth_cmd_decoder #(
      .N_VOICES    (4),
      .FCW_WIDTH   (24),
      .SHIFT_WIDTH (5)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .mod_fcw      (mod_fcw),
      .mod_shift    (mod_shift),
      .synth_shift  (synth_shift),
      .carrier_fcws (carrier_fcws),
      .note_en      (note_en),
      .drop_pulse   (drop_pulse)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the handshake or monitor ever stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [95:0] actual,
                              input logic [95:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Offers one byte and waits (bounded) for the handshake edge.
   task automatic applyStimulus(input logic [7:0] b);
      bit got;
      got = 1'b0;
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      for (int k = 0; k < 50 && !got; k++) begin
         if (rx_ready) got = 1'b1;
         else @(negedge clk);
      end
      vectors++;
      if (!got) begin
         miscompares++;
         $display("[TB] FAIL handshake: byte %0h not accepted, got ready=0, expected 1", b);
      end else begin
         @(posedge clk);
      end
   endtask

   task automatic sendCmd(input logic [7:0] op, input int nArgs,
                          input logic [23:0] arg);
      logic [23:0] a;
      a = arg;
      applyStimulus(op);
      for (int i = 0; i < nArgs; i++) applyStimulus(a[i*8 +: 8]);
   endtask

   task automatic pushExp(input logic d);
      snap_t s;
      s      = expS;
      s.drop = d;
      expQ.push_back(s);
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " mod_fcw"},      96'(mod_fcw),      96'd0);
      checkOutput({tag, " mod_shift"},    96'(mod_shift),    96'd0);
      checkOutput({tag, " synth_shift"},  96'(synth_shift),  96'd0);
      checkOutput({tag, " carrier_fcws"}, carrier_fcws,      96'd0);
      checkOutput({tag, " note_en"},      96'(note_en),      96'd0);
      checkOutput({tag, " drop_pulse"},   96'(drop_pulse),   96'd0);
      checkOutput({tag, " rx_ready"},     96'(rx_ready),     96'd0);
   endtask

   // Monitor: a response is the cycle after EXEC or any drop pulse. EXEC is
   // recognised as rx_ready low once the decoder has been ready since reset.
   initial begin
      bit    armed;
      bit    prevExec;
      bit    curExec;
      int    execRun;
      snap_t s;
      armed    = 1'b0;
      prevExec = 1'b0;
      execRun  = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            armed    = 1'b0;
            prevExec = 1'b0;
            execRun  = 0;
         end else begin
            if (prevExec || drop_pulse) begin
               if (expQ.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("[TB] FAIL unexpected response: drop=%0b note_en=%0h, expected none",
                           drop_pulse, note_en);
               end else begin
                  s = expQ.pop_front();
                  checkOutput("mod_fcw",      96'(mod_fcw),     96'(s.modFcw));
                  checkOutput("mod_shift",    96'(mod_shift),   96'(s.modShift));
                  checkOutput("synth_shift",  96'(synth_shift), 96'(s.synthShift));
                  checkOutput("carrier_fcws", carrier_fcws,     s.carriers);
                  checkOutput("note_en",      96'(note_en),     96'(s.noteEn));
                  checkOutput("drop_pulse",   96'(drop_pulse),  96'(s.drop));
               end
            end
            curExec = armed && !rx_ready;
            if (curExec) begin
               execRun++;
               checkOutput("exec length", 96'(execRun), 96'd1);
            end else begin
               execRun = 0;
            end
            prevExec = curExec;
            if (rx_ready) armed = 1'b1;
         end
      end
   end

   // Directed stimulus with hand-computed expected snapshots.
   initial begin
      rst_n    = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      expS     = '0;
      #1;
      checkAllZero("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Shift set, then mod_fcw and its byte order.
      expS.modShift = 5'd8;            pushExp(1'b0); sendCmd(8'h02, 1, 24'h000008);
      expS.modFcw   = 24'h111111;      pushExp(1'b0); sendCmd(8'h01, 3, 24'h111111);
      expS.modFcw   = 24'hCCBBAA;      pushExp(1'b0); sendCmd(8'h01, 3, 24'hCCBBAA);

      // Note starts fill lowest free voices; a duplicate is dropped.
      expS.carriers[0 +: 24] = 24'h2AAAAA; expS.noteEn = 4'b0001;
      pushExp(1'b0); sendCmd(8'h03, 3, 24'h2AAAAA);
      expS.carriers[24 +: 24] = 24'h0F5A7A; expS.noteEn = 4'b0011;
      pushExp(1'b0); sendCmd(8'h03, 3, 24'h0F5A7A);
      pushExp(1'b1); sendCmd(8'h03, 3, 24'h2AAAAA);

      // Fill the remaining voices, overflow, release, reuse of voice 0.
      expS.carriers[48 +: 24] = 24'h100000; expS.noteEn = 4'b0111;
      pushExp(1'b0); sendCmd(8'h03, 3, 24'h100000);
      expS.carriers[72 +: 24] = 24'h200000; expS.noteEn = 4'b1111;
      pushExp(1'b0); sendCmd(8'h03, 3, 24'h200000);
      pushExp(1'b1); sendCmd(8'h03, 3, 24'h300000);
      expS.noteEn = 4'b1110;
      pushExp(1'b0); sendCmd(8'h04, 3, 24'h2AAAAA);
      pushExp(1'b1); sendCmd(8'h04, 3, 24'h123456);
      expS.carriers[0 +: 24] = 24'h07A120; expS.noteEn = 4'b1111;
      pushExp(1'b0); sendCmd(8'h03, 3, 24'h07A120);

      // Unknown opcode, synth_shift with upper bits ignored, all notes off.
      pushExp(1'b1); sendCmd(8'h09, 0, 24'h0);
      expS.synthShift = 5'd3;  pushExp(1'b0); sendCmd(8'h05, 1, 24'h000003);
      expS.synthShift = 5'h1F; pushExp(1'b0); sendCmd(8'h05, 1, 24'h0000FF);
      expS.synthShift = 5'd3;  pushExp(1'b0); sendCmd(8'h05, 1, 24'h0000E3);
      expS.noteEn = 4'b0000;   pushExp(1'b0); sendCmd(8'h06, 0, 24'h0);
      idle(6);
      checkOutput("queue drained before reset", 96'(expQ.size()), 96'd0);

      // Reset in the middle of a note start clears everything at once.
      applyStimulus(8'h03);
      applyStimulus(8'h11);
      applyStimulus(8'h22);
      @(negedge clk);
      rx_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checkAllZero("mid-cmd reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      expS = '0;
      expS.modShift = 5'd4; pushExp(1'b0); sendCmd(8'h02, 1, 24'h000004);
      idle(10);

      vectors++;
      if (expQ.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL pending responses: got %0d left, expected 0", expQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/synth_cmd_decoder.md
Name: synth_cmd_decoder

Overview:
- Consumes the UART receiver's byte stream and decodes host commands into the synth control registers and per-voice carrier state.
- Inputs: opcode byte plus little-endian argument bytes.
- Outputs: modulator FCW/shift, synth shift, and per-voice carrier FCWs/note enables, with a simple lowest-free-voice allocator.
- Sits between the on-chip UART RX and the FM synth in z1top, replacing the CPU-software command path when selected.

Parameters:
- N_VOICES, 4, number of carrier voices allocated.
- FCW_WIDTH, 24, FCW width in bits; argument byte count = FCW_WIDTH/8 (must be a multiple of 8).
- SHIFT_WIDTH, 5, width of the mod_shift and synth_shift registers.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- rx_data  in  8  byte from UART receiver.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  decoder accepts byte; handshake = rx_valid & rx_ready at posedge clk.
- mod_fcw  out  FCW_WIDTH  modulator FCW.
- mod_shift  out  SHIFT_WIDTH  modulator shift.
- synth_shift  out  SHIFT_WIDTH  output shift.
- carrier_fcws  out  N_VOICES*FCW_WIDTH  voice i at bits [i*FCW_WIDTH +: FCW_WIDTH].
- note_en  out  N_VOICES  voice i active.
- drop_pulse  out  1  one-cycle pulse when a command is discarded.

Behaviour:
Reset (async, rst_n=0):
- All outputs 0; rx_ready 0 while reset asserted; state IDLE.

Opcodes:
- 1 = set mod_fcw, FCW_WIDTH/8 args.
- 2 = set mod_shift, 1 arg.
- 3 = note start, FCW_WIDTH/8 args.
- 4 = note release, FCW_WIDTH/8 args.
- 5 = set synth_shift, 1 arg.
- 6 = all notes off, 0 args.
- Any other opcode: byte consumed, drop_pulse asserted next cycle, stay IDLE.

States:
- IDLE:
  - rx_ready=1.
  - On handshake with a valid opcode: latch opcode, load arg counter = arg count.
  - Go to ARGS if args > 0, else EXEC.
- ARGS:
  - rx_ready=1.
  - Each handshake shifts the byte into the argument register, little-endian (first byte -> bits [7:0]), and decrements the counter.
  - On the handshake with counter==1, go to EXEC.
- EXEC:
  - rx_ready=0 (exactly one cycle).
  - Apply the command; outputs are registered at the edge ending EXEC; return to IDLE.
  - Latency: outputs visible 2 clk edges after the last-byte handshake edge.
  - A byte presented during EXEC is held by the UART (not lost) and accepted in IDLE.

Shift commands:
- Register takes arg[SHIFT_WIDTH-1:0]; upper bits are ignored.

Note start (3):
- If any enabled voice already holds an equal FCW: no change, drop_pulse.
- Else if a free voice exists: write the FCW into the lowest-index voice with note_en=0 and set its note_en.
- Else (all voices busy): no change, drop_pulse.

Note release (4):
- Clear note_en of every enabled voice whose FCW equals the argument.
- carrier_fcws entries are left unchanged.
- No match: drop_pulse, no change.

All notes off (6):
- note_en <= 0.

drop_pulse:
- High exactly the cycle after the discarding decision; otherwise 0.

Reset mid-command:
- Aborts the command, clears all state; partial arguments are discarded.

Back-to-back commands:
- No inter-command gap is required beyond the EXEC cycle.

Test Plan:
1. Reset then bytes 02,08 -> 2 edges after the 08 handshake: mod_shift=8; all other outputs still 0; rx_ready low for exactly 1 cycle.
2. Bytes 01,11,11,11 -> mod_fcw=24'h111111 (1118481); byte order check: 01,AA,BB,CC -> mod_fcw=24'hCCBBAA.
3. Note start 03 with FCW 2796202, then 03 with 1006202 -> voice0=2796202, voice1=1006202, note_en=4'b0011; repeating 2796202 -> unchanged and drop_pulse=1 once.
4. Fill all 4 voices, send a fifth start -> drop_pulse; release 04 with 2796202 -> note_en[0]=0; the next start (e.g. 500000) reuses voice0.
5. Unknown opcode 09, then 05,03 -> drop_pulse once, then synth_shift=3 (09 not interpreted as a command start); then 06 -> note_en=0.
6. Assert rst_n low after 03 plus two argument bytes -> all outputs 0 asynchronously; after release, 02,04 -> mod_shift=4 (stale partial argument not applied).
